// File: rtl/seq_hit_monitor.sv
// Window hit monitor behind the 00110 sequence detector: lifetime hit count, per-window report
// over valid/ready, sticky overrun, and an optional sticky alarm built only when SEQ_MON_ALARM_EN is defined.
module seq_hit_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 64,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             hit_in,
  output logic [CNT_W-1:0] tot_cnt,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_data,
  output logic             overrun,
  output logic             alarm,
  output logic             fsm_state
);

  localparam int               POS_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [POS_W-1:0] win_pos;
  logic [CNT_W-1:0] win_hits;
  logic             close;
  logic             accept;
  logic [CNT_W-1:0] close_val;

  assign fsm_state = (state == RUN);

  // Counting is qualified by en itself, so the first enabled cycle after IDLE already counts.
  always_comb begin
    close     = en && (win_pos == LAST_POS);
    accept    = rpt_valid && rpt_ready;
    close_val = win_hits;
    if (hit_in && (win_hits != CNT_MAX)) close_val = win_hits + CNT_W'(1);
  end

  // Report port: a report transfers on any cycle with rpt_valid && rpt_ready; rpt_data never
  // changes while rpt_valid is high except when a close coincides with that transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      win_pos   <= '0;
      win_hits  <= '0;
      tot_cnt   <= '0;
      rpt_valid <= 1'b0;
      rpt_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (en)  state <= RUN;
        RUN:     if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (clr) begin
        win_pos   <= '0;
        win_hits  <= '0;
        tot_cnt   <= '0;
        rpt_valid <= 1'b0;
        rpt_data  <= '0;
        overrun   <= 1'b0;
      end else begin
        if (en && hit_in && (tot_cnt != CNT_MAX)) tot_cnt <= tot_cnt + CNT_W'(1);

        if (en) begin
          if (close) begin
            win_pos  <= '0;
            win_hits <= '0;
          end else begin
            win_pos  <= win_pos + POS_W'(1);
            win_hits <= close_val;
          end
        end

        // A close while the previous report is still unaccepted drops the new value.
        if (close) begin
          if (!rpt_valid || rpt_ready) begin
            rpt_data  <= close_val;
            rpt_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else if (accept) begin
          rpt_valid <= 1'b0;
        end
      end
    end
  end

`ifdef SEQ_MON_ALARM_EN
  logic alarm_q;

  // The alarm follows the closing count even when that report itself is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      alarm_q <= 1'b0;
    end else if (close && (close_val >= CNT_W'(THRESH))) begin
      alarm_q <= 1'b1;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule
